icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch stage (`i_addr`/`instr`/`i_hit`) and main memory. Hits return the instruction combinationally in the cycle the address is presented. On a miss it fills the whole line from memory, one word per handshake, while the fetch stage stalls on `i_hit`=0. The pipeline's existing `i_hit` stall path needs no change.

## Interface
Parameters:
- `LINES`, 8: number of lines; power of two, 2..64.
- `WORDS`, 4: 16-bit words per line; power of two, 2..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_addr`  in  16  word address from PC.
- `instr`  out  16  instruction word; valid only when `i_hit`=1.
- `i_hit`  out  1  requested word present this cycle.
- `flush`  in  1  one-cycle pulse: invalidate all lines.
- `mem_re`  out  1  word read request to memory.
- `mem_addr`  out  16  word address of the request.
- `mem_rdata`  in  16  memory read data.
- `mem_rdy`  in  1  memory returns `mem_rdata` for the current request this cycle.

## Operation
- Address split: offset = low log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage is flop-based: valid[LINES], tag[LINES], data[LINES][WORDS]. Reads are combinational.
- Hit condition: `i_hit` = valid[index] & (tag[index] == addr tag) & (state == IDLE) & !`flush`.
- `instr` = data[index][offset] when `i_hit`=1; otherwise 16'h0000.
- FSM states:
  - IDLE: on a miss with `flush`=0, latch fill_tag and fill_index from `i_addr`, clear word counter `cnt`, clear `poison`, then go to FILL.
  - FILL: `mem_re`=1, `mem_addr`={fill_tag, fill_index, cnt}.
    - On `mem_rdy`: write `mem_rdata` to data[fill_index][cnt] and increment `cnt`.
    - On `mem_rdy` with `cnt`==WORDS-1: write tag[fill_index] = fill_tag, set valid[fill_index] = !`poison`, go to IDLE.
- Words fill in order 0..WORDS-1 regardless of the missing offset. There is no critical-word-first.
- `mem_re` is held high until `mem_rdy`. `mem_addr` is stable while `mem_re`=1. Memory may take any number of cycles per word.
- Flush:
  - In IDLE, clears all valid bits on the next edge. `i_hit` is forced to 0 in the flush cycle.
  - In FILL, clears all valid bits and sets `poison`. The fill runs to completion, so the memory handshake is never abandoned, but the line is left invalid. The refetch then misses again and refills.
  - Flush on the final `mem_rdy` cycle has `poison` take effect, so the line stays invalid.
- `i_addr` changing during FILL (e.g. a jump redirect) does not abort the fill. After returning to IDLE, the new address is looked up normally.
- Data and tag arrays are not reset. Only valid bits, FSM state, `cnt` and `poison` are reset.

## Timing
- Reset: state=IDLE, all valid=0, `cnt`=0, `poison`=0, `mem_re`=0, `mem_addr`=0, `i_hit`=0, `instr`=0.
- Hit latency: 0 cycles (combinational from `i_addr`).
- Miss, with memory latency L cycles per word (`mem_rdy` on the Lth FILL cycle of each word):
  - cycle 0: miss detected;
  - cycles 1..WORDS·L: FILL;
  - cycle WORDS·L+1: IDLE, and `i_hit`=1 if `i_addr` is unchanged.
  - Total miss penalty is WORDS·L+1 cycles.
- `mem_re` rises in the first FILL cycle, not in the miss cycle.
- `rst` mid-fill returns to IDLE next edge with `mem_re`=0. Memory must tolerate a dropped request.
- Back-to-back misses to different lines: the second FILL starts the cycle after the first returns to IDLE.

## Configuration
- `ICACHE_STATS_EN` defined adds two outputs, `hit_cnt[15:0]` and `miss_cnt[15:0]`:
  - `hit_cnt` counts cycles with `i_hit`=1.
  - `miss_cnt` counts IDLE→FILL transitions.
  - Both saturate at 16'hFFFF, are cleared by `rst`, and are unaffected by `flush`.
- Not defined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then `i_addr`=16'h0000 with memory returning word address+16'h1000, L=1:
  - `i_hit`=0 for 5 cycles;
  - `mem_addr` goes 0,1,2,3;
  - then `i_hit`=1 with `instr`=16'h1000.
  - Addresses 1..3 then hit with 16'h1001..16'h1003.
- Conflict (LINES=8, WORDS=4): fill 16'h0000, then access 16'h0020 (same index, tag differs) → miss and refill. Then 16'h0000 → miss again.
- L=3 memory: miss penalty is exactly 13 cycles, and `mem_addr` is stable for 3 cycles per word.
- `flush` pulse in IDLE with a valid line at 16'h0004: `i_hit`=0 in the flush cycle, and the next access to 16'h0004 misses.
- `flush` during the third word of a fill: the fill completes (4 `mem_rdy`), the line stays invalid, and the next cycle misses and refills.
- `rst` asserted mid-FILL: next cycle `mem_re`=0, state IDLE, all lines invalid. With `ICACHE_STATS_EN`: `hit_cnt` and `miss_cnt` read 0 after reset and match the scenario counts otherwise.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with in-order line fill from word-wide memory.
// Define ICACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module icache #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    output logic [15:0] instr,
    output logic        i_hit,
    input  logic        flush,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 16 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [15:0]      data_mem [LINES][WORDS];

    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_index;
    logic [OFF_W-1:0] cnt;
    logic             poison;

    logic [OFF_W-1:0] addr_off;
    logic [IDX_W-1:0] addr_idx;
    logic [TAG_W-1:0] addr_tag;
    logic             lookup_hit;
    logic             start_fill;
    logic             word_done;
    logic             last_word;

    assign addr_off   = i_addr[OFF_W-1:0];
    assign addr_idx   = i_addr[OFF_W +: IDX_W];
    assign addr_tag   = i_addr[15 -: TAG_W];
    assign lookup_hit = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);

    always_comb begin
        state_next = state;
        i_hit      = 1'b0;
        instr      = 16'h0000;
        mem_re     = 1'b0;
        mem_addr   = 16'h0000;
        start_fill = 1'b0;
        word_done  = 1'b0;
        last_word  = 1'b0;
        case (state)
            IDLE: begin
                // A flush cycle neither hits nor starts a fill.
                if (!flush) begin
                    if (lookup_hit) begin
                        i_hit = 1'b1;
                        instr = data_mem[addr_idx][addr_off];
                    end else begin
                        start_fill = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                mem_re   = 1'b1;
                mem_addr = {fill_tag, fill_index, cnt};
                if (mem_rdy) begin
                    word_done = 1'b1;
                    if (cnt == LAST_WORD) begin
                        last_word  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            valid  <= '0;
            cnt    <= '0;
            poison <= 1'b0;
        end else begin
            state <= state_next;
            if (start_fill) begin
                cnt    <= '0;
                poison <= 1'b0;
            end else if (word_done) begin
                cnt <= cnt + 1'b1;
            end
            if (flush) begin
                valid <= '0;
                if (state == FILL) begin
                    poison <= 1'b1;
                end
            end
            // A flush landing on the final word must still leave the line invalid.
            if (last_word) begin
                valid[fill_index] <= !(poison || flush);
            end
        end
    end

    // Tag/data storage and fill address are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (start_fill) begin
            fill_tag   <= addr_tag;
            fill_index <= addr_idx;
        end
        if (word_done) begin
            data_mem[fill_index][cnt] <= mem_rdata;
        end
        if (last_word) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (i_hit && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'h0001;
            end
            if (start_fill && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (LINES=8, WORDS=4) with a variable-latency memory model
// that returns word address + 16'h1000.
module tb_icache;

    logic        clk;
    logic        rst;
    logic [15:0] i_addr;
    logic [15:0] instr;
    logic        i_hit;
    logic        flush;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int vectors;
    int miscompares;
    int mem_lat;
    int wait_cnt;
    int rdy_seen;
    int rdy_before;

    icache #(
        .LINES(8),
        .WORDS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_addr   (i_addr),
        .instr    (instr),
        .i_hit    (i_hit),
        .flush    (flush),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers on the mem_lat-th cycle of each request.
    assign mem_rdy   = mem_re && (wait_cnt == mem_lat - 1);
    assign mem_rdata = mem_addr + 16'h1000;

    always @(posedge clk) begin
        if (!mem_re || mem_rdy) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (mem_rdy) rdy_seen <= rdy_seen + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present addr in IDLE, expect a miss, walk the whole fill, then expect the hit.
    task automatic run_miss(input logic [15:0] addr, input int lat);
        logic [15:0] base;
        base   = addr & 16'hFFFC;
        i_addr = addr;
        #1;
        check("miss_hit", {15'd0, i_hit}, 16'd0);
        check("miss_re", {15'd0, mem_re}, 16'd0);
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < lat; c++) begin
                tick();
                check("fill_re", {15'd0, mem_re}, 16'd1);
                check("fill_addr", mem_addr, base + 16'(w));
                check("fill_hit", {15'd0, i_hit}, 16'd0);
            end
        end
        tick();
        check("post_hit", {15'd0, i_hit}, 16'd1);
        check("post_instr", instr, addr + 16'h1000);
        check("post_re", {15'd0, mem_re}, 16'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mem_lat     = 1;
        wait_cnt    = 0;
        rdy_seen    = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        i_addr      = 16'h0000;
        tick();
        tick();

        check("rst_hit", {15'd0, i_hit}, 16'd0);
        check("rst_instr", instr, 16'h0000);
        check("rst_re", {15'd0, mem_re}, 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
`ifdef ICACHE_STATS_EN
        check("rst_hitcnt", hit_cnt, 16'd0);
        check("rst_misscnt", miss_cnt, 16'd0);
`endif

        // Cold miss at 0, then the rest of the line hits.
        rst = 1'b0;
        run_miss(16'h0000, 1);
        for (int a = 1; a < 4; a++) begin
            i_addr = 16'(a);
            #1;
            check("line_hit", {15'd0, i_hit}, 16'd1);
            check("line_instr", instr, 16'h1000 + 16'(a));
        end
        tick();

        // Conflict on index 0: 0x0020 evicts 0x0000, which then misses again.
        run_miss(16'h0020, 1);
        tick();
        run_miss(16'h0000, 1);
        tick();

        // Three-cycle memory: 13-cycle penalty, address held 3 cycles per word.
        mem_lat = 3;
        run_miss(16'h0046, 3);
        tick();
        mem_lat = 1;

        // Flush in IDLE with 0x0004 valid.
        run_miss(16'h0004, 1);
        tick();
        flush = 1'b1;
        #1;
        check("flush_idle_hit", {15'd0, i_hit}, 16'd0);
        check("flush_idle_re", {15'd0, mem_re}, 16'd0);
        tick();
        flush = 1'b0;
        run_miss(16'h0004, 1);
        tick();

        // Flush during the third word: fill completes but the line stays invalid.
        i_addr = 16'h0008;
        rdy_before = rdy_seen;
        tick();
        tick();
        tick();
        flush = 1'b1;
        #1;
        check("pflush_addr2", mem_addr, 16'h000A);
        tick();
        flush = 1'b0;
        #1;
        check("pflush_addr3", mem_addr, 16'h000B);
        tick();
        check("pflush_rdys", 16'(rdy_seen - rdy_before), 16'd4);
        check("pflush_hit", {15'd0, i_hit}, 16'd0);
        check("pflush_re", {15'd0, mem_re}, 16'd0);
        run_miss(16'h0008, 1);
        tick();

        // Flush coinciding with the final mem_rdy.
        i_addr = 16'h000C;
        tick();
        tick();
        tick();
        tick();
        flush = 1'b1;
        #1;
        check("lflush_addr3", mem_addr, 16'h000F);
        check("lflush_rdy", {15'd0, mem_rdy}, 16'd1);
        tick();
        flush = 1'b0;
        #1;
        check("lflush_hit", {15'd0, i_hit}, 16'd0);
        tick();
        check("lflush_refill_re", {15'd0, mem_re}, 16'd1);
        check("lflush_refill_addr", mem_addr, 16'h000C);
        for (int k = 0; k < 3; k++) tick();
        tick();
        check("lflush_post_hit", {15'd0, i_hit}, 16'd1);
        check("lflush_post_instr", instr, 16'h100C);
        tick();

        // Reset mid-fill drops the request and invalidates everything.
        i_addr = 16'h0010;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_re", {15'd0, mem_re}, 16'd0);
        check("midrst_addr", mem_addr, 16'h0000);
`ifdef ICACHE_STATS_EN
        check("midrst_hitcnt", hit_cnt, 16'd0);
        check("midrst_misscnt", miss_cnt, 16'd0);
`endif
        run_miss(16'h0000, 1);
        tick();
        i_addr = 16'h0001;
        #1;
        check("final_instr", instr, 16'h1001);
        tick();
`ifdef ICACHE_STATS_EN
        check("stats_hitcnt", hit_cnt, 16'd2);
        check("stats_misscnt", miss_cnt, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a wedged run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
